// File: rtl/mem_pin_host.sv
// mem_pin_host
//   Host-side initiator for the 16-bit DFF-memory pin protocol. Each request
//   accepted on the valid/ready request channel is turned into this target
//   pin sequence:
//     SETUP  : target held in reset, {3'b000, we, addr} on the bus
//     ACCESS : target released, write data on the bus (zero for reads)
//     RESP   : target parked, tgt_dout captured on the last ACCESS cycle
//   Exactly one response is returned per request, and only one request is
//   in flight at a time.
//
// Parameters
//   SETUP_CYC   cycles the target is held in reset with {we, addr} (1..15)
//   ACCESS_CYC  cycles the target is released before tgt_dout is sampled (2..15)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata     request payload, sampled only at the accept edge
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_we     captured target output, echo of the request type
//   tgt_rst_n, tgt_bus    registered drives to target rst_n and {ui_in, uio_in}
//   tgt_dout              target {uo_out, uio_out}
//   busy                  high in every state except IDLE
module mem_pin_host #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACCESS_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_we,
  output logic        tgt_rst_n,
  output logic [15:0] tgt_bus,
  input  logic [15:0] tgt_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        we_q, we_nx;
  logic [11:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;

  logic        req_ready_nx;
  logic        rsp_valid_nx;
  logic [15:0] rsp_rdata_nx;
  logic        rsp_we_nx;
  logic        tgt_rst_n_nx;
  logic [15:0] tgt_bus_nx;
  logic        busy_nx;

  // Every output is a flop; the values below are what each output must show
  // during the state being entered, so pins change only on clock edges.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    we_nx        = we_q;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_we_nx    = rsp_we;
    tgt_rst_n_nx = tgt_rst_n;
    tgt_bus_nx   = tgt_bus;

    case (state)
      IDLE: begin
        tgt_rst_n_nx = 1'b0;
        tgt_bus_nx   = '0;
        if (req_valid && req_ready) begin
          we_nx      = req_we;
          addr_nx    = req_addr;
          wdata_nx   = req_wdata;
          cnt_nx     = SETUP_LD;
          state_nx   = SETUP;
          // Bus is loaded straight from the request so SETUP shows it at once.
          tgt_bus_nx = {3'b000, req_we, req_addr};
        end
      end

      SETUP: begin
        if (cnt == 4'd0) begin
          cnt_nx       = ACCESS_LD;
          state_nx     = ACCESS;
          tgt_rst_n_nx = 1'b1;
          tgt_bus_nx   = we_q ? wdata_q : '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end

      ACCESS: begin
        if (cnt == 4'd0) begin
          rsp_rdata_nx = tgt_dout;
          rsp_we_nx    = we_q;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
          // Park: target latches we=0/addr=0 so no stale write survives.
          tgt_rst_n_nx = 1'b0;
          tgt_bus_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end

      RESP: begin
        tgt_rst_n_nx = 1'b0;
        tgt_bus_nx   = '0;
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx     = IDLE;
        rsp_valid_nx = 1'b0;
        tgt_rst_n_nx = 1'b0;
        tgt_bus_nx   = '0;
      end
    endcase

    req_ready_nx = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
      tgt_rst_n <= 1'b0;
      tgt_bus   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      we_q      <= we_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_we    <= rsp_we_nx;
      tgt_rst_n <= tgt_rst_n_nx;
      tgt_bus   <= tgt_bus_nx;
      busy      <= busy_nx;
    end
  end

endmodule
